// File: rtl/bitrev_ctrl_pkg.sv
// bitrev_ctrl_pkg
//   Shared definitions for the bitrev SPI master controller: FSM state
//   encoding and the transaction shape (bits out, bits in, SCK periods).
package bitrev_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_HOLD  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam int BITS_TX = 8;
   localparam int BITS_RX = 8;
   localparam int PERIODS = 16;
   localparam int HALVES  = 2 * PERIODS;

endpackage

// File: rtl/bitrev_ctrl_if.sv
// bitrev_ctrl_if
//   CPU-side request/response handshake of the bitrev SPI master.
//   req_valid/req_ready/req_data    : byte to send, accepted on valid & ready
//   resp_valid/resp_ready/resp_data : reply byte, held until valid & ready
//   master modport : bus adapter side
//   slave modport  : controller side
interface bitrev_ctrl_if;
   import bitrev_ctrl_pkg::*;

   logic               req_valid;
   logic               req_ready;
   logic [BITS_TX-1:0] req_data;
   logic               resp_valid;
   logic               resp_ready;
   logic [BITS_RX-1:0] resp_data;

   modport master (
      output req_valid, req_data, resp_ready,
      input  req_ready, resp_valid, resp_data
   );

   modport slave (
      input  req_valid, req_data, resp_ready,
      output req_ready, resp_valid, resp_data
   );

endinterface

// File: rtl/bitrev_ctrl_spi_clk_div.sv
// spi_clk_div
//   SCK half-period timer. While en is high it counts DIV clk cycles per
//   half period and alternates between the high and low half. When en is
//   low the counter and phase are held cleared, so the first half after
//   enabling is always the high half.
//   clk, rst : system clock, asynchronous active-high reset
//   en       : run the timer
//   fall     : one-cycle strobe on the cycle whose edge ends a high half
//   rise     : one-cycle strobe on the cycle whose edge ends a low half
module spi_clk_div #(
   parameter int DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic rise,
   output logic fall
);

   localparam int            CW = $clog2(DIV) + 1;
   localparam logic [CW-1:0] TC = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          phase_q, phase_d;   // 0: high half, 1: low half
   logic          term;

   assign term = en && (cnt_q == TC);
   assign fall = term && !phase_q;
   assign rise = term && phase_q;

   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (!en) begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end else if (term) begin
         cnt_d   = '0;
         phase_d = !phase_q;
      end else begin
         cnt_d   = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

endmodule

// File: rtl/bitrev_ctrl.sv
// bitrev_ctrl
//   SPI master that runs one full exchange with the bitrev peripheral per
//   request: 8 SCK periods sending req_data MSB first on MOSI, then 8 more
//   periods collecting the reply from MISO (first bit into bit 0).
//   clk, rst  : system clock, asynchronous active-high reset
//   bus       : request/response handshake (slave side)
//   spi_sck   : serial clock, idles low
//   spi_ss    : slave select, active low
//   spi_mosi  : master out, idles high
//   spi_miso  : slave in
//   DIV       : SCK half period in clk cycles (>= 1)
module bitrev_ctrl
   import bitrev_ctrl_pkg::*;
#(
   parameter int DIV = 2
) (
   input  logic         clk,
   input  logic         rst,
   bitrev_ctrl_if.slave bus,
   output logic         spi_sck,
   output logic         spi_ss,
   output logic         spi_mosi,
   input  logic         spi_miso
);

   localparam int            CW        = $clog2(DIV) + 1;
   localparam logic [CW-1:0] TC        = CW'(DIV - 1);
   localparam logic [4:0]    EDGE_LAST = 5'(HALVES - 1);

   state_t             state_q, state_d;
   logic [BITS_TX-1:0] tx_q, tx_d;
   logic [BITS_RX-1:0] rx_q, rx_d;
   logic [4:0]         edge_q, edge_d;    // current half period within SHIFT
   logic [CW-1:0]      wait_q, wait_d;    // SETUP / HOLD duration
   logic               sck_q, sck_d;
   logic               ss_q, ss_d;
   logic               mosi_q, mosi_d;
   logic               div_en, sck_rise, sck_fall, wait_done, active_d;

   assign div_en    = (state_q == ST_SHIFT);
   assign wait_done = (wait_q == TC);

   spi_clk_div #(.DIV(DIV)) u_div (
      .clk  (clk),
      .rst  (rst),
      .en   (div_en),
      .rise (sck_rise),
      .fall (sck_fall)
   );

   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      edge_d  = edge_q;
      wait_d  = '0;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               tx_d    = bus.req_data;
               rx_d    = '0;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (wait_done) state_d = ST_SHIFT;
            else           wait_d  = wait_q + CW'(1);
         end
         ST_SHIFT: begin
            if (sck_fall) begin
               // Periods 1..8 shift out with 1-fill, so MOSI settles high
               // after the eighth falling edge; periods 9..16 capture MISO.
               if (!edge_q[4]) tx_d = {tx_q[BITS_TX-2:0], 1'b1};
               else            rx_d[edge_q[3:1]] = spi_miso;
            end
            if (sck_rise || sck_fall) begin
               if (edge_q == EDGE_LAST) begin
                  edge_d  = '0;
                  state_d = ST_HOLD;
               end else begin
                  edge_d  = edge_q + 5'd1;
               end
            end
         end
         ST_HOLD: begin
            if (wait_done) state_d = ST_DONE;
            else           wait_d  = wait_q + CW'(1);
         end
         ST_DONE: begin
            if (bus.resp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Pins are registered from the next state so they switch cleanly
      // together with the state register.
      active_d = (state_d == ST_SETUP) || (state_d == ST_SHIFT) || (state_d == ST_HOLD);
      ss_d     = !active_d;
      mosi_d   = active_d ? tx_d[BITS_TX-1] : 1'b1;
      sck_d    = 1'b0;
      if (state_d == ST_SHIFT) begin
         if (state_q == ST_SETUP) sck_d = 1'b1;
         else if (sck_fall)       sck_d = 1'b0;
         else if (sck_rise)       sck_d = 1'b1;
         else                     sck_d = sck_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         tx_q    <= '0;
         rx_q    <= '0;
         edge_q  <= '0;
         wait_q  <= '0;
         sck_q   <= 1'b0;
         ss_q    <= 1'b1;
         mosi_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         edge_q  <= edge_d;
         wait_q  <= wait_d;
         sck_q   <= sck_d;
         ss_q    <= ss_d;
         mosi_q  <= mosi_d;
      end
   end

   assign bus.req_ready  = (state_q == ST_IDLE);
   assign bus.resp_valid = (state_q == ST_DONE);
   assign bus.resp_data  = rx_q;
   assign spi_sck        = sck_q;
   assign spi_ss         = ss_q;
   assign spi_mosi       = mosi_q;

endmodule

// File: tb/tb_bitrev_ctrl.sv
// tb_bitrev_ctrl
//   Three controllers (DIV = 2, 1, 5) each wired to a behavioural bitrev
//   peripheral. Accepted requests push the bit-reversed byte into a
//   scoreboard; completed responses pop and compare. A negedge monitor
//   also tracks latency, SCK rise counts, SCK half widths, MOSI stability
//   and the SS high gap.
module tb_bitrev_ctrl;

   localparam int NI = 3;

   logic       clk;
   logic       rst;
   logic       req_valid  [NI];
   logic [7:0] req_data   [NI];
   logic       resp_ready [NI];
   logic       req_ready  [NI];
   logic       resp_valid [NI];
   logic [7:0] resp_data  [NI];
   logic       sck  [NI];
   logic       ss   [NI];
   logic       mosi [NI];
   logic       miso [NI];

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   int         exp_inst [$];
   logic [7:0] exp_data [$];

   int   acc_cyc    [NI] = '{default: 0};
   int   acc_gap    [NI] = '{default: 0};
   bit   acc_seen   [NI] = '{default: 1'b0};
   int   resp_cnt   [NI] = '{default: 0};
   int   rises_cur  [NI] = '{default: 0};
   int   rises_last [NI] = '{default: 0};
   int   mosi_bad   [NI] = '{default: 0};
   int   width_bad  [NI] = '{default: 0};
   int   run        [NI] = '{default: 0};
   int   ssh        [NI] = '{default: 0};
   int   gap_last   [NI] = '{default: 0};
   logic prev_ss    [NI] = '{default: 1'b1};
   logic prev_sck   [NI] = '{default: 1'b0};
   logic prev_mosi  [NI] = '{default: 1'b1};
   logic prev_rv    [NI] = '{default: 1'b0};

   function automatic int div_of(input int i);
      return (i == 0) ? 2 : ((i == 1) ? 1 : 5);
   endfunction

   function automatic logic [7:0] rev8(input logic [7:0] d);
      logic [7:0] r;
      for (int b = 0; b < 8; b++) r[b] = d[7-b];
      return r;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < NI; g++) begin : g_inst
      localparam int D = (g == 0) ? 2 : ((g == 1) ? 1 : 5);

      bitrev_ctrl_if bus ();

      assign bus.req_valid  = req_valid[g];
      assign bus.req_data   = req_data[g];
      assign bus.resp_ready = resp_ready[g];
      assign req_ready[g]   = bus.req_ready;
      assign resp_valid[g]  = bus.resp_valid;
      assign resp_data[g]   = bus.resp_data;

      bitrev_ctrl #(.DIV(D)) u_dut (
         .clk      (clk),
         .rst      (rst),
         .bus      (bus),
         .spi_sck  (sck[g]),
         .spi_ss   (ss[g]),
         .spi_mosi (mosi[g]),
         .spi_miso (miso[g])
      );

      // Behavioural bitrev peripheral: takes 8 bits MSB first on rises
      // 1..8, then returns them MSB first on rises 9..16.
      logic       sck_w, ss_w, mosi_w, pmiso;
      int         pcnt = 0;
      logic [7:0] psh  = '0;
      assign sck_w   = sck[g];
      assign ss_w    = ss[g];
      assign mosi_w  = mosi[g];
      assign miso[g] = pmiso;
      initial pmiso = 1'b0;

      always @(posedge sck_w or posedge ss_w) begin
         if (ss_w) begin
            pcnt  <= 0;
            pmiso <= 1'b0;
         end else begin
            pcnt <= pcnt + 1;
            if (pcnt < 8)       psh   <= {psh[6:0], mosi_w};
            else if (pcnt < 16) pmiso <= psh[15-pcnt];
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         if (rst) begin
            prev_ss[i]   <= 1'b1;
            prev_sck[i]  <= 1'b0;
            prev_mosi[i] <= 1'b1;
            prev_rv[i]   <= 1'b0;
            run[i]       <= 0;
            rises_cur[i] <= 0;
         end else begin
            if (req_valid[i] && req_ready[i]) begin
               exp_inst.push_back(i);
               exp_data.push_back(rev8(req_data[i]));
               if (acc_seen[i]) acc_gap[i] <= cyc - acc_cyc[i];
               acc_cyc[i]  <= cyc;
               acc_seen[i] <= 1'b1;
            end
            if (resp_valid[i] && !prev_rv[i])
               check_val("resp_latency", cyc - acc_cyc[i], 1 + 34 * div_of(i));
            if (resp_valid[i] && resp_ready[i]) begin
               if (exp_data.size() == 0) begin
                  check_val("resp_unexpected", exp_data.size(), 1);
               end else begin
                  check_val("resp_inst", i, exp_inst[0]);
                  check_val("resp_data", resp_data[i], exp_data[0]);
                  exp_inst.delete(0);
                  exp_data.delete(0);
               end
               resp_cnt[i] <= resp_cnt[i] + 1;
            end

            if (sck[i] && !prev_sck[i] && !ss[i]) rises_cur[i] <= rises_cur[i] + 1;
            else if (!ss[i] && prev_ss[i])        rises_cur[i] <= 0;
            if (ss[i] && !prev_ss[i]) rises_last[i] <= rises_cur[i];

            if ((mosi[i] != prev_mosi[i]) && sck[i]) mosi_bad[i] <= mosi_bad[i] + 1;

            // While SS is low every SCK level lasts DIV cycles, except the
            // last low run (period 16 low half plus HOLD) which lasts 2*DIV.
            if (!ss[i]) begin
               if (!prev_ss[i] && (sck[i] == prev_sck[i])) begin
                  run[i] <= run[i] + 1;
               end else begin
                  if (!prev_ss[i] && (run[i] != div_of(i))) width_bad[i] <= width_bad[i] + 1;
                  run[i] <= 1;
               end
            end else begin
               if (!prev_ss[i] && (run[i] != 2 * div_of(i))) width_bad[i] <= width_bad[i] + 1;
               run[i] <= 0;
            end

            if (ss[i])           ssh[i]      <= prev_ss[i] ? ssh[i] + 1 : 1;
            else if (prev_ss[i]) gap_last[i] <= ssh[i];

            prev_ss[i]   <= ss[i];
            prev_sck[i]  <= sck[i];
            prev_mosi[i] <= mosi[i];
            prev_rv[i]   <= resp_valid[i];
         end
      end
   end

   task automatic send(input int i, input logic [7:0] d);
      int n;
      n = 0;
      req_valid[i] = 1'b1;
      req_data[i]  = d;
      @(negedge clk);
      while (!req_ready[i] && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check_val("accept_in_time", n < 1000, 1);
      @(posedge clk); #1;
      req_valid[i] = 1'b0;
   endtask

   task automatic wait_resp(input int i, input int target);
      int n;
      n = 0;
      while (resp_cnt[i] < target && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      check_val("resp_in_time", resp_cnt[i] >= target, 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b0;
      for (int i = 0; i < NI; i++) begin
         req_valid[i]  = 1'b0;
         req_data[i]   = 8'h00;
         resp_ready[i] = 1'b1;
      end
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      check_val("rst_req_ready",  req_ready[0],  1'b1);
      check_val("rst_resp_valid", resp_valid[0], 1'b0);
      check_val("rst_resp_data",  resp_data[0],  8'h00);
      check_val("rst_sck",        sck[0],        1'b0);
      check_val("rst_ss",         ss[0],         1'b1);
      check_val("rst_mosi",       mosi[0],       1'b1);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk); #1;

      // single byte at DIV=2
      send(0, 8'h01);
      wait_resp(0, 1);
      check_val("rises_01", rises_last[0], 16);

      // back-to-back with resp_ready held high
      send(0, 8'hA5);
      send(0, 8'h3C);
      wait_resp(0, 3);
      check_val("b2b_period", acc_gap[0], 70);
      check_val("b2b_ss_gap_ge2", gap_last[0] >= 2, 1);
      check_val("rises_3c", rises_last[0], 16);

      // response stalled for 10 cycles, competing request ignored
      resp_ready[0] = 1'b0;
      send(0, 8'h12);
      n = 0;
      while (!resp_valid[0] && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      check_val("stall_valid", resp_valid[0], 1'b1);
      req_valid[0] = 1'b1;
      req_data[0]  = 8'h77;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check_val("stall_data",      resp_data[0], 8'h48);
         check_val("stall_req_ready", req_ready[0], 1'b0);
         check_val("stall_pins",      {ss[0], sck[0], mosi[0]}, 3'b101);
      end
      @(posedge clk); #1;
      req_valid[0]  = 1'b0;
      resp_ready[0] = 1'b1;
      wait_resp(0, 4);
      repeat (3) @(posedge clk); #1;
      check_val("stall_no_extra", exp_data.size(), 0);

      // reset during SHIFT period 5
      send(0, 8'hF0);
      n = 0;
      while (!(rises_cur[0] == 5 && sck[0]) && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      check_val("p5_reached", n < 1000, 1);
      rst = 1'b1;
      #1;
      check_val("abort_ss",         ss[0],         1'b1);
      check_val("abort_sck",        sck[0],        1'b0);
      check_val("abort_mosi",       mosi[0],       1'b1);
      check_val("abort_resp_valid", resp_valid[0], 1'b0);
      check_val("abort_req_ready",  req_ready[0],  1'b1);
      @(posedge clk); #1;
      rst = 1'b0;
      exp_inst.delete();
      exp_data.delete();
      repeat (2) @(posedge clk); #1;
      check_val("abort_no_resp", resp_cnt[0], 4);
      send(0, 8'hF0);
      wait_resp(0, 5);
      check_val("rises_f0", rises_last[0], 16);

      // DIV sweep
      send(1, 8'hC3);
      wait_resp(1, 1);
      check_val("div1_rises", rises_last[1], 16);
      send(2, 8'hC3);
      wait_resp(2, 1);
      check_val("div5_rises", rises_last[2], 16);

      repeat (3) @(posedge clk); #1;
      for (int i = 0; i < NI; i++) begin
         check_val("mosi_while_sck_high", mosi_bad[i], 0);
         check_val("sck_half_width", width_bad[i], 0);
      end
      check_val("scoreboard_empty", exp_data.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
